// File: rtl/db_cmd_parser_if.sv
// db_cmd_parser_if: UART byte stream and MCU debug-port signals of the command parser.
interface db_cmd_parser_if;
    logic [7:0] rx_data;
    logic rx_valid;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic [31:0] pc;
    logic mcu_busy;
    logic [31:0] d_rd;
    logic error;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic valid;
    logic pause;
    logic resume;
    logic mcu_reset;
    logic reg_rd;
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic [3:0] mem_be;
    modport master (
        input rx_data, rx_valid, tx_ready, pc, mcu_busy, d_rd, error,
        output tx_data, tx_valid, addr, d_in, valid, pause, resume, mcu_reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be
    );
    modport slave (
        output rx_data, rx_valid, tx_ready, pc, mcu_busy, d_rd, error,
        input tx_data, tx_valid, addr, d_in, valid, pause, resume, mcu_reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be
    );
endinterface

// File: rtl/db_cmd_parser.sv
// db_cmd_parser: assembles UART host frames into single-cycle MCU debug commands and returns replies.
// Define DB_CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every known frame.
module db_cmd_parser #(
    parameter int unsigned BYTE_TIMEOUT = 1000000,
    parameter int unsigned BUSY_TIMEOUT = 65536
) (
    input logic clk,
    input logic reset,
    db_cmd_parser_if.master bus
);
    localparam logic [7:0] OP_PAUSE = 8'h01, OP_RESUME = 8'h02, OP_RESET = 8'h03, OP_REG_RD = 8'h04;
    localparam logic [7:0] OP_REG_WR = 8'h05, OP_MEM_RD = 8'h06, OP_MEM_WR = 8'h07, OP_MEM_WB = 8'h08;
    localparam logic [7:0] OP_STATUS = 8'h09;
    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, ISSUE, WAIT, RESP, ERR
`ifdef DB_CMD_CHECKSUM_EN
        , CHK
`endif
    } state_t;
    state_t state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [31:0] addr_q, addr_d, din_q, din_d, word_q, word_d, cnt_q, cnt_d;
    logic [3:0] be_q, be_d;
    logic [1:0] idx_q, idx_d;
    logic multi_q, multi_d;
    logic framing, fin, exec, issue;
`ifdef DB_CMD_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif
    function automatic logic needs_addr(input logic [7:0] op);
        return op inside {[OP_REG_RD:OP_MEM_WB]};
    endfunction
    function automatic logic needs_data(input logic [7:0] op);
        return op inside {OP_REG_WR, OP_MEM_WR, OP_MEM_WB};
    endfunction
    function automatic logic is_read(input logic [7:0] op);
        return op inside {OP_REG_RD, OP_MEM_RD};
    endfunction
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        addr_d = addr_q;
        din_d = din_q;
        word_d = word_q;
        be_d = be_q;
        idx_d = idx_q;
        multi_d = multi_q;
        cnt_d = '0;
        fin = 1'b0;
        exec = 1'b0;
`ifdef DB_CMD_CHECKSUM_EN
        csum_d = csum_q;
        framing = state_q inside {ADDR, DATA, CHK};
`else
        framing = state_q inside {ADDR, DATA};
`endif
        // a stalled host abandons the partial frame silently
        if (framing && !bus.rx_valid) begin
            cnt_d = cnt_q + 32'd1;
            state_d = (cnt_q == BYTE_TIMEOUT - 1) ? IDLE : state_q;
        end
        case (state_q)
            IDLE: if (bus.rx_valid) begin
                op_d = bus.rx_data;
                idx_d = 2'd0;
`ifdef DB_CMD_CHECKSUM_EN
                csum_d = bus.rx_data;
`endif
                state_d = !(bus.rx_data inside {[OP_PAUSE:OP_STATUS]}) ? ERR : needs_addr(bus.rx_data) ? ADDR : IDLE;
                fin = bus.rx_data inside {OP_PAUSE, OP_RESUME, OP_RESET, OP_STATUS};
            end
            ADDR, DATA: if (bus.rx_valid) begin
                idx_d = idx_q + 2'd1;
`ifdef DB_CMD_CHECKSUM_EN
                csum_d = csum_q ^ bus.rx_data;
`endif
                if (state_q == ADDR) addr_d = {addr_q[23:0], bus.rx_data};
                else din_d = {din_q[23:0], bus.rx_data};
                if (idx_q == 2'd3) begin
                    state_d = (state_q == ADDR && needs_data(op_q)) ? DATA : state_q;
                    fin = !(state_q == ADDR && needs_data(op_q));
                end
            end
`ifdef DB_CMD_CHECKSUM_EN
            CHK: if (bus.rx_valid) begin
                exec = bus.rx_data == csum_q;
                if (bus.rx_data != csum_q) begin
                    state_d = RESP;
                    word_d = {8'hFD, 24'h0};
                    multi_d = 1'b0;
                    idx_d = 2'd0;
                end
            end
`endif
            ISSUE: state_d = WAIT;
            WAIT: if (!bus.mcu_busy) begin
                state_d = RESP;
                idx_d = 2'd0;
                multi_d = is_read(op_q);
                word_d = is_read(op_q) ? bus.d_rd : {bus.error ? 8'hFE : 8'h00, 24'h0};
            end else begin
                cnt_d = cnt_q + 32'd1;
                state_d = (cnt_q == BUSY_TIMEOUT - 1) ? ERR : WAIT;
            end
            RESP: if (bus.tx_ready) begin
                word_d = {word_q[23:0], 8'h00};
                idx_d = idx_q + 2'd1;
                state_d = (!multi_q || idx_q == 2'd3) ? IDLE : RESP;
            end
            ERR: state_d = bus.tx_ready ? IDLE : ERR;
            default: state_d = IDLE;
        endcase
`ifdef DB_CMD_CHECKSUM_EN
        if (fin) state_d = CHK;
`else
        exec = fin;
`endif
        // status is answered locally; everything else goes to the MCU
        if (exec && op_d == OP_STATUS) begin
            state_d = RESP;
            word_d = bus.pc;
            multi_d = 1'b1;
            idx_d = 2'd0;
        end else if (exec) begin
            state_d = ISSUE;
            din_d = (op_d == OP_MEM_WB) ? {4{din_d[7:0]}} : din_d;
            be_d = (op_d == OP_MEM_WB) ? 4'b0001 << addr_d[1:0] : (op_d == OP_MEM_WR) ? 4'hF : 4'h0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q <= '0;
            addr_q <= '0;
            din_q <= '0;
            word_q <= '0;
            cnt_q <= '0;
            be_q <= '0;
            idx_q <= '0;
            multi_q <= 1'b0;
`ifdef DB_CMD_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            addr_q <= addr_d;
            din_q <= din_d;
            word_q <= word_d;
            cnt_q <= cnt_d;
            be_q <= be_d;
            idx_q <= idx_d;
            multi_q <= multi_d;
`ifdef DB_CMD_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end
    assign issue = state_q == ISSUE;
    assign bus.valid = issue;
    assign bus.pause = issue && op_q == OP_PAUSE;
    assign bus.resume = issue && op_q == OP_RESUME;
    assign bus.mcu_reset = issue && op_q == OP_RESET;
    assign bus.reg_rd = issue && op_q == OP_REG_RD;
    assign bus.reg_wr = issue && op_q == OP_REG_WR;
    assign bus.mem_rd = issue && op_q == OP_MEM_RD;
    assign bus.mem_wr = issue && (op_q == OP_MEM_WR || op_q == OP_MEM_WB);
    assign bus.addr = addr_q;
    assign bus.d_in = din_q;
    assign bus.mem_be = be_q;
    assign bus.tx_valid = state_q inside {RESP, ERR};
    assign bus.tx_data = (state_q == ERR) ? 8'hFF : (state_q == RESP) ? word_q[31:24] : 8'h00;
endmodule

// File: tb/tb_db_cmd_parser.sv
// tb_db_cmd_parser: randomized host frames checked against a byte-level reply and strobe model.
// Honours DB_CMD_CHECKSUM_EN by appending the XOR checksum byte to known frames.
module tb_db_cmd_parser;
    localparam int BT = 64;
    localparam int BU = 40;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int stray = 0;
    logic [6:0] cap_type;
    logic [31:0] cap_addr, cap_din;
    logic [3:0] cap_be;
    db_cmd_parser_if bus ();
    db_cmd_parser #(.BYTE_TIMEOUT(BT), .BUSY_TIMEOUT(BU)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    wire [6:0] types = {bus.pause, bus.resume, bus.mcu_reset, bus.reg_rd, bus.reg_wr, bus.mem_rd, bus.mem_wr};
    always @(negedge clk) begin
        if (!reset && bus.valid) begin
            nvalid <= nvalid + 1;
            cap_type <= types;
            cap_addr <= bus.addr;
            cap_din <= bus.d_in;
            cap_be <= bus.mem_be;
        end
        if (!reset && !bus.valid && |types) stray <= stray + 1;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask
    // busy < 0 keeps mcu_busy stuck high
    task automatic frame(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] drd, input int busy, input bit err, input bit bad, input int maxgap);
        logic [7:0] bytes[$];
        logic [7:0] exp[$];
        logic [7:0] got[$];
        logic [7:0] sum;
        logic [31:0] pcv;
        bit known, issue, issued, bad_sum;
        int n0, s0, left, vcyc, first, dropped, extra;
        known = op inside {[8'h01:8'h09]};
        issue = known && op != 8'h09;
        pcv = $urandom;
        bus.pc = pcv;
        bytes = {op};
        if (op inside {[8'h04:8'h08]}) for (int i = 3; i >= 0; i--) bytes.push_back(a[8*i +: 8]);
        if (op inside {8'h05, 8'h07, 8'h08}) for (int i = 3; i >= 0; i--) bytes.push_back(d[8*i +: 8]);
`ifdef DB_CMD_CHECKSUM_EN
        bad_sum = bad && known;
        if (known) begin
            sum = 8'h00;
            foreach (bytes[i]) sum ^= bytes[i];
            bytes.push_back(sum ^ {7'd0, bad});
        end
`else
        bad_sum = 1'b0;
`endif
        if (!known) exp = {8'hFF};
        else if (bad_sum) begin
            exp = {8'hFD};
            issue = 1'b0;
        end else if (op == 8'h09) for (int i = 3; i >= 0; i--) exp.push_back(pcv[8*i +: 8]);
        else if (busy < 0) exp = {8'hFF};
        else if (op inside {8'h04, 8'h06}) for (int i = 3; i >= 0; i--) exp.push_back(drd[8*i +: 8]);
        else exp = {err ? 8'hFE : 8'h00};
        bus.mcu_busy = 1'b1;
        bus.d_rd = ~drd;
        bus.error = ~err;
        n0 = nvalid;
        s0 = stray;
        foreach (bytes[i]) send(bytes[i], $urandom_range(0, maxgap));
        issued = 1'b0;
        dropped = 0;
        first = -1;
        vcyc = -1;
        left = -1;
        for (int c = 0; c < BU + 100 && got.size() < exp.size(); c++) begin
            bus.rx_valid = 1'b0;
            if (dropped == 1) begin
                bus.d_rd = ~drd;
                bus.error = ~err;
                bus.mcu_busy = 1'b1;
                dropped = 2;
            end
            if (issued && left > 0) begin
                left--;
                if (left == 0) begin
                    bus.mcu_busy = 1'b0;
                    bus.d_rd = drd;
                    bus.error = err;
                    dropped = 1;
                end
            end
            if (bus.valid && !issued) begin
                issued = 1'b1;
                vcyc = c;
                left = (busy < 0) ? -1 : busy + 1;
            end
            if (issued && c == vcyc + 1) begin
                bus.rx_data = 8'h42;
                bus.rx_valid = 1'b1;
            end
            bus.tx_ready = $urandom_range(0, 2) != 0;
            if (bus.tx_valid) begin
                if (first < 0) first = c;
                if (bus.tx_ready) got.push_back(bus.tx_data);
            end
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        extra = 0;
        repeat (4) begin
            bus.tx_ready = 1'b1;
            if (bus.tx_valid) extra++;
            @(negedge clk);
        end
        check({tag, " extra_tx"}, extra, 0);
        check({tag, " n_bytes"}, got.size(), exp.size());
        foreach (exp[i]) if (i < got.size()) check($sformatf("%s byte%0d", tag, i), got[i], exp[i]);
        check({tag, " n_valid"}, nvalid - n0, issue ? 1 : 0);
        check({tag, " stray_strobe"}, stray - s0, 0);
        if (issue && nvalid - n0 == 1) begin
            check({tag, " type"}, cap_type, (op == 8'h08) ? 7'b0000001 : 7'(7'b1000000 >> (op - 8'd1)));
            if (op inside {[8'h04:8'h08]}) check({tag, " addr"}, cap_addr, a);
            if (op inside {8'h05, 8'h07, 8'h08}) check({tag, " d_in"}, cap_din, (op == 8'h08) ? {4{d[7:0]}} : d);
            if (op inside {8'h07, 8'h08}) check({tag, " mem_be"}, cap_be, (op == 8'h07) ? 4'hF : 4'(1 << a[1:0]));
            if (busy >= 0) check({tag, " latency"}, first - vcyc, busy + 2);
        end
    endtask
    initial begin
        int t, n0, busy;
        bit bad;
        logic [7:0] op;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_ready = 1'b0;
        bus.pc = 32'h0;
        bus.mcu_busy = 1'b0;
        bus.d_rd = 32'h0;
        bus.error = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx_valid", bus.tx_valid, 0);
        check("rst tx_data", bus.tx_data, 0);
        check("rst strobes", {bus.valid, types}, 0);
        check("rst addr_din_be", {bus.addr, bus.d_in, bus.mem_be}, 0);
        reset = 1'b0;
        frame("memwr", 8'h07, 32'h10, 32'hDEADBEEF, 32'h0, 10, 1'b0, 1'b0, 3);
        frame("memrd", 8'h06, 32'h10, 32'h0, 32'hDEADBEEF, 4, 1'b0, 1'b0, 3);
        frame("memwb", 8'h08, 32'h13, 32'h5A, 32'h0, 2, 1'b0, 1'b0, 3);
        frame("regwr_err", 8'h05, 32'h8000_0004, 32'h1234_5678, 32'h0, 3, 1'b1, 1'b0, 2);
        frame("regrd_busy0", 8'h04, 32'h0000_0021, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 1);
        frame("slow_gaps", 8'h05, 32'hA5A5_0001, 32'h0F0F_F0F0, 32'h0, 1, 1'b0, 1'b0, BT - 8);
        n0 = nvalid;
        send(8'h04, 0);
        send(8'h00, 1);
        send(8'h00, 1);
        t = 0;
        repeat (BT + 5) begin
            if (bus.tx_valid) t++;
            @(negedge clk);
        end
        check("byte_timeout tx", t, 0);
        check("byte_timeout valid", nvalid - n0, 0);
        frame("status", 8'h09, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 2);
        frame("busy_stuck", 8'h01, 32'h0, 32'h0, 32'h0, -1, 1'b0, 1'b0, 2);
        frame("unknown", 8'h42, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 2);
`ifdef DB_CMD_CHECKSUM_EN
        frame("sum_ok", 8'h02, 32'h0, 32'h0, 32'h0, 1, 1'b0, 1'b0, 2);
        frame("sum_bad", 8'h02, 32'h0, 32'h0, 32'h0, 1, 1'b0, 1'b1, 2);
`endif
        bus.mcu_busy = 1'b1;
        n0 = nvalid;
        send(8'h03, 0);
`ifdef DB_CMD_CHECKSUM_EN
        send(8'h03, 0);
`endif
        check("rst_wait issue", bus.valid, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait outputs", {bus.tx_valid, bus.tx_data, bus.valid, types, bus.addr, bus.d_in, bus.mem_be}, 0);
        reset = 1'b0;
        bus.mcu_busy = 1'b0;
        t = 0;
        repeat (BU + 10) begin
            bus.tx_ready = 1'b1;
            if (bus.tx_valid) t++;
            @(negedge clk);
        end
        check("rst_wait no_tx", t, 0);
        check("rst_wait n_valid", nvalid - n0, 1);
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(1, 9));
            busy = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            bad = 1'b0;
`ifdef DB_CMD_CHECKSUM_EN
            bad = $urandom_range(0, 5) == 0;
`endif
            frame($sformatf("rnd%0d", i), op, $urandom, $urandom, $urandom, busy, 1'($urandom), bad, 3);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
